nibble_serializer: RTL and testbench



---
 rtl/nibble_pkg.sv | 22 ++
 rtl/nibble_serializer_if.sv | 48 ++++
 rtl/nibble_serializer_ctrl.sv | 58 +++++
 rtl/nibble_serializer.sv | 101 ++++++++++
 tb/tb_nibble_serializer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/nibble_pkg.sv
// ============================================================================
// Module : nibble_pkg
// Brief  : Shared constants for the nibble serializer and its 4-bit consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nibble_pkg;

  localparam int NIBBLE_W = 4;

  // State encoding is shared with the consumer-side controller.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serializer_if.sv
// ============================================================================
// Module : nibble_serializer_if
// Brief  : Load and nibble-stream handshake bundle for nibble_serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nibble_serializer_if #(
  parameter int NIBBLES = 4
);
  import nibble_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic [W-1:0]          load_word;
  logic                  load_valid;
  logic                  load_ready;
  logic [NIBBLE_W-1:0]   dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output load_word,
    output load_valid,
    input  load_ready,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  busy,
    input  done
  );

  modport slave (
    input  load_word,
    input  load_valid,
    output load_ready,
    output dout,
    output dout_valid,
    input  dout_ready,
    output busy,
    output done
  );

endinterface

`default_nettype wire

// File: rtl/nibble_serializer_ctrl.sv
// ============================================================================
// Module : nibble_serializer_ctrl
// Brief  : IDLE/SEND controller; decodes load, shift and last-transfer strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_serializer_ctrl
  import nibble_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load_valid,
  input  logic             dout_ready,
  input  logic [CNT_W-1:0] count,
  output logic             load_ready,
  output logic             load_en,
  output logic             shift_en,
  output logic             last_en
);

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic       w_count_zero;
  logic       w_xfer;

  // dout_valid is high for the whole of SEND, so a transfer is SEND && ready.
  always_comb begin
    w_count_zero = (count == '0);
    w_xfer       = (r_state == ST_SEND) && dout_ready;
    load_ready   = (r_state == ST_IDLE);
    load_en      = (r_state == ST_IDLE) && load_valid;
    shift_en     = w_xfer && !w_count_zero;
    last_en      = w_xfer && w_count_zero;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (load_valid) w_state_next = ST_SEND;
      ST_SEND: if (last_en)    w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nibble_serializer.sv
// ============================================================================
// Module : nibble_serializer
// Brief  : Serializes a 4*NIBBLES-bit word into a valid/ready nibble stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int NIBBLES   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 rst,
  nibble_serializer_if.slave   bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [W-1:0]        r_shift;
  logic [CNT_W-1:0]    r_count;
  logic [NIBBLE_W-1:0] r_dout;
  logic                r_dout_valid;
  logic                r_busy;
  logic                r_done;

  logic [W-1:0]        w_shifted;
  logic [NIBBLE_W-1:0] w_load_head;
  logic [NIBBLE_W-1:0] w_next_head;
  logic                w_load_en;
  logic                w_shift_en;
  logic                w_last_en;

  // The output end of the shift register depends on nibble order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted   = r_shift << NIBBLE_W;
      assign w_load_head = bus.load_word[W-1 -: NIBBLE_W];
      assign w_next_head = w_shifted[W-1 -: NIBBLE_W];
    end else begin : g_lsb_first
      assign w_shifted   = r_shift >> NIBBLE_W;
      assign w_load_head = bus.load_word[NIBBLE_W-1:0];
      assign w_next_head = w_shifted[NIBBLE_W-1:0];
    end
  endgenerate

  nibble_serializer_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clock      (clock),
    .rst        (rst),
    .load_valid (bus.load_valid),
    .dout_ready (bus.dout_ready),
    .count      (r_count),
    .load_ready (bus.load_ready),
    .load_en    (w_load_en),
    .shift_en   (w_shift_en),
    .last_en    (w_last_en)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last_en;
      if (w_load_en) begin
        r_shift      <= bus.load_word;
        r_count      <= c_cnt_last;
        r_dout       <= w_load_head;
        r_dout_valid <= 1'b1;
        r_busy       <= 1'b1;
      end else if (w_shift_en) begin
        r_shift <= w_shifted;
        r_count <= r_count - c_cnt_one;
        r_dout  <= w_next_head;
      end else if (w_last_en) begin
        // dout keeps the final nibble after the stream ends
        r_dout_valid <= 1'b0;
        r_busy       <= 1'b0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serializer.sv
// ============================================================================
// Module : tb_nibble_serializer
// Brief  : Directed and random checks of three serializer configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nibble_serializer;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] load_word = '0;
  logic        lv = 1'b0;
  logic        dr = 1'b0;
  int          sel = 0;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] obs_dout;
  logic       obs_valid, obs_busy, obs_done, obs_lready;

  always #5 clock = ~clock;

  nibble_serializer_if #(.NIBBLES(4)) if_a ();
  nibble_serializer_if #(.NIBBLES(4)) if_b ();
  nibble_serializer_if #(.NIBBLES(1)) if_c ();

  assign if_a.load_word  = load_word;
  assign if_b.load_word  = load_word;
  assign if_c.load_word  = load_word[3:0];
  assign if_a.load_valid = lv && (sel == 0);
  assign if_b.load_valid = lv && (sel == 1);
  assign if_c.load_valid = lv && (sel == 2);
  assign if_a.dout_ready = dr;
  assign if_b.dout_ready = dr;
  assign if_c.dout_ready = dr;

  nibble_serializer #(.NIBBLES(4), .MSB_FIRST(1'b1)) u_msb4 (.clock(clock), .rst(rst), .bus(if_a));
  nibble_serializer #(.NIBBLES(4), .MSB_FIRST(1'b0)) u_lsb4 (.clock(clock), .rst(rst), .bus(if_b));
  nibble_serializer #(.NIBBLES(1), .MSB_FIRST(1'b1)) u_one  (.clock(clock), .rst(rst), .bus(if_c));

  always_comb begin
    obs_dout = if_a.dout; obs_valid = if_a.dout_valid; obs_busy = if_a.busy;
    obs_done = if_a.done; obs_lready = if_a.load_ready;
    if (sel == 1) begin
      obs_dout = if_b.dout; obs_valid = if_b.dout_valid; obs_busy = if_b.busy;
      obs_done = if_b.done; obs_lready = if_b.load_ready;
    end else if (sel == 2) begin
      obs_dout = if_c.dout; obs_valid = if_c.dout_valid; obs_busy = if_c.busy;
      obs_done = if_c.done; obs_lready = if_c.load_ready;
    end
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on 2nd nibble
  task automatic send_word(input int sel_i, input logic [15:0] word, input int mode, input bit beef);
    logic [3:0] expq[$];
    logic [3:0] got[$];
    int n, cyc, stall, idx;
    bit msb;
    sel = sel_i;
    n   = (sel_i == 2) ? 1 : 4;
    msb = (sel_i != 1);
    for (int k = 0; k < n; k++) begin
      idx = msb ? (n - 1 - k) : k;
      expq.push_back(4'((word >> (4 * idx)) & 16'h000F));
    end
    @(negedge clock);
    check_bit("load_ready_idle", obs_lready, 1'b1);
    load_word = word; lv = 1'b1; dr = (mode == 0);
    @(posedge clock); #1;
    if (beef) load_word = 16'hBEEF; else lv = 1'b0;
    cyc = 0; stall = 0;
    while (got.size() < n && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) check_bit("first_valid", obs_valid, 1'b1);
      case (mode)
        0: dr = 1'b1;
        1: dr = ($urandom_range(0, 2) != 0);
        default: begin
          if (got.size() == 1 && stall < 3) begin
            dr = 1'b0; stall++;
            check_val("bp_hold_dout", 16'(obs_dout), 16'(expq[1]));
            check_bit("bp_hold_valid", obs_valid, 1'b1);
          end else dr = 1'b1;
        end
      endcase
      if (obs_valid && dr) begin
        got.push_back(obs_dout);
        if (got.size() == n) lv = 1'b0;
      end
    end
    check_val("xfer_count", 16'(got.size()), 16'(n));
    for (int k = 0; k < n; k++)
      check_val("nibble", (k < got.size()) ? 16'(got[k]) : 16'hxxxx, 16'(expq[k]));
    if (mode == 0) check_val("throughput_cycles", 16'(cyc), 16'(n));
    @(negedge clock);
    dr = 1'b0;
    check_bit("done_pulse", obs_done, 1'b1);
    check_bit("valid_low_after", obs_valid, 1'b0);
    check_bit("busy_low_after", obs_busy, 1'b0);
    check_bit("load_ready_back", obs_lready, 1'b1);
    @(negedge clock);
    check_bit("done_one_cycle", obs_done, 1'b0);
    check_bit("no_capture", obs_busy, 1'b0);
  endtask

  initial begin
    int cnt;
    // Reset held with a pending load
    sel = 0; load_word = 16'hA5C3; lv = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_bit("rst_valid", obs_valid, 1'b0);
    check_bit("rst_busy", obs_busy, 1'b0);
    check_bit("rst_done", obs_done, 1'b0);
    check_val("rst_dout", 16'(obs_dout), 16'h0);
    rst = 1'b0;
    @(posedge clock); #1 lv = 1'b0;
    @(negedge clock);
    check_bit("post_rst_valid", obs_valid, 1'b1);
    check_val("post_rst_dout", 16'(obs_dout), 16'hA);
    dr = 1'b1;
    cnt = 0;
    while (obs_busy && cnt < 20) begin @(negedge clock); cnt++; end
    check_bit("post_rst_drained", obs_busy, 1'b0);
    dr = 1'b0;
    @(negedge clock);

    send_word(0, 16'hA5C3, 0, 1'b0);
    send_word(0, 16'hA5C3, 2, 1'b0);
    send_word(0, 16'h1234, 0, 1'b1);
    send_word(0, 16'hBEEF, 0, 1'b0);
    send_word(1, 16'hA5C3, 0, 1'b0);
    send_word(2, 16'h0007, 0, 1'b0);

    // Reset after two of four nibbles
    sel = 0;
    @(negedge clock);
    load_word = 16'h9876; lv = 1'b1;
    @(posedge clock); #1 lv = 1'b0; dr = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      @(negedge clock);
      if (obs_valid && dr) cnt++;
    end
    @(negedge clock);
    rst = 1'b1;
    #1;
    check_bit("midword_rst_valid", obs_valid, 1'b0);
    check_bit("midword_rst_busy", obs_busy, 1'b0);
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check_bit("no_residual", obs_valid, 1'b0);
    end
    dr = 1'b0;
    send_word(0, 16'hFFFF, 0, 1'b0);

    for (int i = 0; i < 12; i++)
      send_word(int'($urandom_range(0, 2)), 16'($urandom), 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
